// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time writer for the instruction memory. Consumes a framed byte stream
//   from the host link:
//     LEN_LO, LEN_HI (N words, 16-bit little-endian),
//     4*N payload bytes, CSUM (XOR of all payload bytes).
//   The payload is packed into 32-bit little-endian words. The words are written
//   to consecutive addresses starting at 0 through a single synchronous write
//   port.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   start     one-cycle pulse; arms the loader from IDLE/DONE/ERROR
//   in_data   stream byte
//   in_valid  in_data is valid
//   in_ready  loader accepts a byte (transfer = in_valid & in_ready)
//   wr_addr   word address of the current write
//   wr_data   word to write
//   wr_en     write strobe, one cycle per word
//   busy      a frame is in progress (LEN0..CSUM)
//   done      frame loaded and checksum matched (sticky until start/rst)
//   error     oversize length or checksum mismatch (sticky until start/rst)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Largest legal word count, widened by one bit so that N == 2**ADDR_WIDTH
    // can be represented and compared.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t      state;
    state_t      state_next;

    logic [15:0] length;
    logic [15:0] word_cnt;
    logic [15:0] word_cnt_inc;
    logic [1:0]  lane;
    logic [7:0]  checksum;
    logic [23:0] byte_buf;     // first three bytes of the word being assembled

    logic        accept;
    logic        arm;
    logic [15:0] len_full;
    logic        len_oversize;
    logic        len_zero;
    logic        word_last;

    // Moore outputs: both are decoded from the registered state only.
    assign in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign busy     = in_ready;

    assign accept       = in_valid & in_ready;
    assign arm          = start && ((state == S_IDLE) || (state == S_DONE) ||
                                    (state == S_ERROR));
    // The word count is complete once the high byte is on the bus in LEN1.
    assign len_full     = {in_data, length[7:0]};
    assign len_oversize = {1'b0, len_full} > CAPACITY;
    assign len_zero     = (len_full == 16'd0);
    assign word_cnt_inc = word_cnt + 16'd1;
    assign word_last    = (word_cnt_inc == length);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: every clocked process uses non-blocking assignments so that
            // all registers update from the same pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment comes first so that every path through
        // the case assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN0;
            end
            S_LEN0: begin
                if (accept) state_next = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if (len_oversize)  state_next = S_ERROR;
                    else if (len_zero) state_next = S_CSUM;
                    else               state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (lane == 2'd3) && word_last) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_next = (in_data == checksum) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write port, checksum and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length   <= '0;
            word_cnt <= '0;
            lane     <= '0;
            checksum <= '0;
            byte_buf <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse. wr_addr and wr_data hold their value.
            wr_en <= 1'b0;

            if (arm) begin
                length   <= '0;
                word_cnt <= '0;
                lane     <= '0;
                checksum <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
            end

            if (accept) begin
                unique case (state)
                    S_LEN0: length[7:0] <= in_data;
                    S_LEN1: begin
                        length[15:8] <= in_data;
                        if (len_oversize) error <= 1'b1;
                    end
                    S_DATA: begin
                        checksum <= checksum ^ in_data;
                        lane     <= lane + 2'd1;
                        unique case (lane)
                            2'd0: byte_buf[7:0]   <= in_data;
                            2'd1: byte_buf[15:8]  <= in_data;
                            2'd2: byte_buf[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word. It is written on
                                // the next edge, which may coincide with the
                                // CSUM byte being accepted.
                                wr_en    <= 1'b1;
                                wr_addr  <= word_cnt[ADDR_WIDTH-1:0];
                                wr_data  <= {in_data, byte_buf};
                                word_cnt <= word_cnt_inc;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        if (in_data == checksum) done  <= 1'b1;
                        else                     error <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader (ADDR_WIDTH = 10). Bytes are driven on the
//   falling edge. Outputs are sampled on the falling edge. A monitor records
//   every write strobe so that the bench can compare address and data order
//   against hand-computed words.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] w_addr_q[$];
    logic [31:0]   w_data_q[$];
    logic [31:0]   frame_words[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            w_addr_q.push_back(wr_addr);
            w_data_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_writes();
        w_addr_q.delete();
        w_data_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return on the falling edge after it has been taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    // Send LEN, the words in frame_words (little-endian), then csum.
    task automatic send_frame(input logic [15:0] n, input logic [7:0] csum, input int maxgap);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
        foreach (frame_words[k]) begin
            for (int j = 0; j < 4; j++)
                send_byte(8'(frame_words[k] >> (8 * j)),
                          (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        send_byte(csum, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_busy"},  32'(busy),     32'd0);
    endtask

    initial begin
        int errs;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wren",  32'(wr_en),    32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_error", 32'(error),    32'd0);
        check("rst_addr",  32'(wr_addr),  32'd0);
        check("rst_data",  wr_data,       32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // N=1, 0xDEADBEEF, CSUM = EF^BE^AD^DE = 0x22.
        clear_writes();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        frame_words = '{32'hDEADBEEF};
        send_frame(16'd1, 8'h22, 0);
        check("t1_nwr",  32'(w_addr_q.size()), 32'd1);
        check("t1_addr", 32'(w_addr_q[0]), 32'd0);
        check("t1_data", w_data_q[0], 32'hDEADBEEF);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err",  32'(error), 32'd0);
        check_idle_outputs("t1");

        // N=3, words 1,2,3 with random gaps. CSUM = 1^2^3 = 0.
        clear_writes();
        pulse_start();
        frame_words = '{32'h1, 32'h2, 32'h3};
        send_frame(16'd3, 8'h00, 2);
        check("t2_nwr", 32'(w_addr_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("t2_addr", 32'(w_addr_q[k]), 32'(k));
            check("t2_data", w_data_q[k], 32'(k + 1));
        end
        check("t2_done", 32'(done), 32'd1);

        // N=2, real CSUM = 0x04 ^ 0x0C = 0x08. Send 0x09 instead.
        clear_writes();
        pulse_start();
        frame_words = '{32'h04030201, 32'h08070605};
        send_frame(16'd2, 8'h09, 0);
        check("t3_nwr",   32'(w_addr_q.size()), 32'd2);
        check("t3_data0", w_data_q[0], 32'h04030201);
        check("t3_addr1", 32'(w_addr_q[1]), 32'd1);
        check("t3_data1", w_data_q[1], 32'h08070605);
        check("t3_err",   32'(error), 32'd1);
        check("t3_done",  32'(done),  32'd0);

        // N=0x0401 exceeds 1024 words: error right after LEN_HI.
        clear_writes();
        pulse_start();
        check("t4_err_clr", 32'(error), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        in_valid = 1'b0;
        check("t4_err",   32'(error), 32'd1);
        check("t4_done",  32'(done),  32'd0);
        check_idle_outputs("t4");
        repeat (4) @(negedge clk);
        check("t4_nwr", 32'(w_addr_q.size()), 32'd0);

        // N=0 with start plus a junk byte in IDLE-equivalent state. The junk byte
        // must not be taken as LEN_LO.
        clear_writes();
        start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        frame_words.delete();
        send_frame(16'd0, 8'h00, 0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_nwr",  32'(w_addr_q.size()), 32'd0);
        // Reload: 0x12345678, CSUM = 78^56^34^12 = 0x08.
        pulse_start();
        check("t5_done_clr", 32'(done), 32'd0);
        frame_words = '{32'h12345678};
        send_frame(16'd1, 8'h08, 0);
        check("t5_done2", 32'(done), 32'd1);
        check("t5_data",  w_data_q[0], 32'h12345678);

        // N=1024 (full capacity). Word i = i. Byte XOR over the whole range is 0.
        clear_writes();
        pulse_start();
        frame_words.delete();
        for (int i = 0; i < 1024; i++) frame_words.push_back(32'(i));
        send_frame(16'd1024, 8'h00, 0);
        check("t6_nwr",   32'(w_addr_q.size()), 32'd1024);
        check("t6_laddr", 32'(w_addr_q[1023]), 32'h3FF);
        check("t6_ldata", w_data_q[1023], 32'd1023);
        errs = 0;
        for (int i = 0; i < 1024; i++)
            if (w_addr_q[i] != AW'(i) || w_data_q[i] != 32'(i)) errs++;
        check("t6_order", 32'(errs), 32'd0);
        check("t6_done",  32'(done), 32'd1);

        // Reset after 6 payload bytes of an N=2 frame.
        clear_writes();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        send_byte(8'h33, 0); send_byte(8'h44, 0);
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t7_nwr",   32'(w_addr_q.size()), 32'd1);
        check("t7_addr",  32'(w_addr_q[0]), 32'd0);
        check("t7_data",  w_data_q[0], 32'h44332211);
        check("t7_ready", 32'(in_ready), 32'd0);
        check("t7_busy",  32'(busy),     32'd0);
        check("t7_wren",  32'(wr_en),    32'd0);
        check("t7_done",  32'(done),     32'd0);
        check("t7_err",   32'(error),    32'd0);
        check("t7_waddr", 32'(wr_addr),  32'd0);
        check("t7_wdata", wr_data,       32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t7_nwr2", 32'(w_addr_q.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
